// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types for the up/down counter
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

endpackage

// File: rtl/counter_next_calc.sv
// rtl/counter_next_calc.sv - combinational next count, end-of-range event and done set
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_limit,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_up,
    input  mode_e            i_mode,
    output logic [WIDTH-1:0] o_count,
    output logic             o_event,
    output logic             o_done_set
);

    // One extra bit so sums past the limit and limit+1 never alias.
    logic [WIDTH:0] w_count_x;
    logic [WIDTH:0] w_limit_x;
    logic [WIDTH:0] w_step_x;
    logic [WIDTH:0] w_range;
    logic [WIDTH:0] w_sum;

    assign w_count_x = {1'b0, i_count};
    assign w_limit_x = {1'b0, i_limit};
    assign w_step_x  = {1'b0, i_step};
    assign w_range   = w_limit_x + 1'b1;
    assign w_sum     = w_count_x + w_step_x;

    always_comb begin
        o_count    = i_count;
        o_event    = 1'b0;
        o_done_set = 1'b0;
        if (i_up) begin
            o_event = (w_sum > w_limit_x);
            if (!o_event) begin
                o_count = WIDTH'(w_sum);
            end else begin
                case (i_mode)
                    MODE_SAT:     o_count = i_limit;
                    MODE_ONESHOT: begin
                        o_count    = i_limit;
                        o_done_set = 1'b1;
                    end
                    default:      o_count = WIDTH'(w_sum - w_range);
                endcase
            end
        end else begin
            o_event = (w_count_x < w_step_x);
            if (!o_event) begin
                o_count = WIDTH'(w_count_x - w_step_x);
            end else begin
                case (i_mode)
                    MODE_SAT:     o_count = '0;
                    MODE_ONESHOT: begin
                        o_count    = '0;
                        o_done_set = 1'b1;
                    end
                    default:      o_count = WIDTH'(w_count_x + w_range - w_step_x);
                endcase
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - up/down counter with programmable limit, step and end-of-range mode
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_n,
    input  logic             ce,
    input  logic             up_down,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count_out,
    output logic             max_count,
    output logic             zero,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic             r_done;
    logic             r_tc;
    logic             r_ovf;

    mode_e            w_mode;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_event;
    logic             w_done_set;
    logic             w_active;
    logic             w_fire;

    assign w_mode   = mode_e'(mode);
    assign w_step   = (step > r_limit) ? r_limit : step;
    // A zero effective step is a pure hold: no movement and no event.
    assign w_active = ce && !r_done && (w_step != '0);
    assign w_fire   = w_active && w_event;

    counter_next_calc #(.WIDTH(WIDTH)) u_next_calc (
        .i_count    (r_count),
        .i_limit    (r_limit),
        .i_step     (w_step),
        .i_up       (up_down),
        .i_mode     (w_mode),
        .o_count    (w_next),
        .o_event    (w_event),
        .o_done_set (w_done_set)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_limit <= '1;
            r_done  <= 1'b0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (!load_n) begin
            r_limit <= limit;
            r_count <= (data_load > limit) ? limit : data_load;
            r_done  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= w_fire;
            if (w_active) begin
                r_count <= w_next;
            end
            // Set beats clear when an event lands on the same edge.
            if (w_fire) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_mode != MODE_ONESHOT) begin
                r_done <= 1'b0;
            end else if (w_fire && w_done_set) begin
                r_done <= 1'b1;
            end
        end
    end

    assign count_out = r_count;
    assign max_count = (r_count == r_limit);
    assign zero      = (r_count == '0);
    assign tc        = r_tc;
    assign ovf       = r_ovf;
    assign done      = r_done;

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - directed self-checking bench for updown_counter_mod
module tb_updown_counter_mod;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load_n;
    logic             ce;
    logic             up_down;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data_load;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] step;
    logic             clr_ovf;
    logic [WIDTH-1:0] count_out;
    logic             max_count;
    logic             zero;
    logic             tc;
    logic             ovf;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    updown_counter_mod #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_n    (load_n),
        .ce        (ce),
        .up_down   (up_down),
        .mode      (mode),
        .data_load (data_load),
        .limit     (limit),
        .step      (step),
        .clr_ovf   (clr_ovf),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero),
        .tc        (tc),
        .ovf       (ovf),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] l);
        load_n    = 1'b0;
        data_load = d;
        limit     = l;
        tick();
        load_n    = 1'b1;
    endtask

    initial begin
        rst = 1'b1; load_n = 1'b1; ce = 1'b1; up_down = 1'b1; mode = 2'd0;
        data_load = '0; limit = '0; step = 4'd1; clr_ovf = 1'b0;
        tick();
        check("rst_count", count_out, 0);
        check("rst_zero", zero, 1);
        check("rst_max", max_count, 0);
        check("rst_tc", tc, 0);
        check("rst_ovf", ovf, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // WRAP up: limit 9, 8 -> 1 -> 4 with step 3
        mode = 2'd0; up_down = 1'b1; step = 4'd3;
        do_load(4'd8, 4'd9);
        check("wrap_load", count_out, 8);
        check("wrap_load_tc", tc, 0);
        tick();
        check("wrap_cnt1", count_out, 1);
        check("wrap_tc1", tc, 1);
        check("wrap_ovf1", ovf, 1);
        tick();
        check("wrap_cnt2", count_out, 4);
        check("wrap_tc2", tc, 0);
        check("wrap_ovf2", ovf, 1);

        // SAT down: limit 15, 2 -> 0 twice with tc each time
        mode = 2'd1; up_down = 1'b0; step = 4'd5;
        do_load(4'd2, 4'd15);
        check("sat_load", count_out, 2);
        tick();
        check("sat_cnt1", count_out, 0);
        check("sat_tc1", tc, 1);
        check("sat_zero", zero, 1);
        tick();
        check("sat_cnt2", count_out, 0);
        check("sat_tc2", tc, 1);
        ce = 1'b0; clr_ovf = 1'b1;
        tick();
        check("sat_clr_ovf", ovf, 0);
        check("sat_clr_tc", tc, 0);
        clr_ovf = 1'b0; ce = 1'b1;

        // ONESHOT up: limit 5, 4 -> 5 -> done
        mode = 2'd2; up_down = 1'b1; step = 4'd1;
        do_load(4'd4, 4'd5);
        check("os_load", count_out, 4);
        tick();
        check("os_cnt1", count_out, 5);
        check("os_max1", max_count, 1);
        check("os_tc1", tc, 0);
        check("os_done1", done, 0);
        tick();
        check("os_cnt2", count_out, 5);
        check("os_done2", done, 1);
        check("os_tc2", tc, 1);
        check("os_ovf2", ovf, 1);
        tick();
        check("os_hold_cnt", count_out, 5);
        check("os_hold_done", done, 1);
        check("os_hold_tc", tc, 0);
        mode = 2'd0;
        tick();
        check("os_mode_done", done, 0);
        check("os_mode_cnt", count_out, 5);
        mode = 2'd2;
        do_load(4'd0, 4'd5);
        check("os_reload_cnt", count_out, 0);
        check("os_reload_done", done, 0);

        // Load clamp and step clamp: data 12 -> 7, step 9 -> 7, 7 -> 6
        mode = 2'd0; up_down = 1'b1; step = 4'd9;
        do_load(4'd12, 4'd7);
        check("clamp_cnt", count_out, 7);
        check("clamp_max", max_count, 1);
        tick();
        check("clamp_wrap_cnt", count_out, 6);
        check("clamp_wrap_tc", tc, 1);

        // Reset wins over load
        rst = 1'b1; load_n = 1'b0; data_load = 4'd3; limit = 4'd7;
        tick();
        check("rst_win_cnt", count_out, 0);
        check("rst_win_max", max_count, 0);
        check("rst_win_ovf", ovf, 0);
        rst = 1'b0; load_n = 1'b1;

        // Event beats clr_ovf: limit 3, 3 + 2 -> 1
        mode = 2'd0; up_down = 1'b1; step = 4'd2;
        do_load(4'd3, 4'd3);
        clr_ovf = 1'b1;
        tick();
        check("setwin_cnt", count_out, 1);
        check("setwin_tc", tc, 1);
        check("setwin_ovf", ovf, 1);
        clr_ovf = 1'b0;

        // Zero step holds without events
        step = 4'd0;
        tick();
        check("step0_cnt", count_out, 1);
        check("step0_tc", tc, 0);

        // WRAP down: 1 - 2 with limit 3 -> 3
        step = 4'd2; up_down = 1'b0;
        tick();
        check("wrapdn_cnt", count_out, 3);
        check("wrapdn_tc", tc, 1);

        // limit 0: both decodes high
        do_load(4'd5, 4'd0);
        check("lim0_cnt", count_out, 0);
        check("lim0_max", max_count, 1);
        check("lim0_zero", zero, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
